// File: rtl/cnn_pkg.sv
// Widths and sample type shared between the convolution engine and its downstream stages.
package cnn_pkg;

  // Default sample width of the conv datapath.
  localparam int SAMPLE_W = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  // Counter width for a range of n values; never narrower than one bit.
  function automatic int LOGSIZE(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pool_out_reg.sv
// Single-entry valid/ready output register. A load arriving while the held result
// is being emitted replaces it, so the stage sustains one result per cycle.
module pool_out_reg #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         y_ready,
  output logic [W-1:0] y_data,
  output logic         y_valid,
  output logic         ready
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t state;

  assign ready = !y_valid || y_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= EMPTY;
      y_valid <= 1'b0;
      y_data  <= '0;
    end else begin
      case (state)
        EMPTY: if (load) begin
          state   <= FULL;
          y_valid <= 1'b1;
          y_data  <= load_data;
        end
        FULL: if (load) begin
          // Upstream only loads when ready, i.e. this result is leaving now.
          y_data  <= load_data;
        end else if (y_ready) begin
          state   <= EMPTY;
          y_valid <= 1'b0;
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/maxpool_1d_stream.sv
// Streaming non-overlapping 1-D max-pool; window size K, frame length L, the last
// window of a frame may be partial and windows never straddle frames.
module maxpool_1d_stream
  import cnn_pkg::*;
#(
  parameter int L = 32,
  parameter int K = 2,
  parameter int T = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [T-1:0] x_data,
  input  logic         x_valid,
  output logic         x_ready,
  output logic [T-1:0] y_data,
  output logic         y_valid,
  input  logic         y_ready
);

  localparam int WW = LOGSIZE(K);
  localparam int FW = LOGSIZE(L);
  localparam logic [WW-1:0] WIN_LAST = WW'(K - 1);
  localparam logic [FW-1:0] FRM_LAST = FW'(L - 1);

  logic [WW-1:0]       win_cnt;
  logic [FW-1:0]       frm_cnt;
  logic signed [T-1:0] max_reg, x_s, win_max;
  logic                accept, close, win_first, frm_last;

  assign x_s       = signed'(x_data);
  assign accept    = x_valid && x_ready;
  assign win_first = (win_cnt == '0);
  assign frm_last  = (frm_cnt == FRM_LAST);
  assign close     = accept && (win_cnt == WIN_LAST || frm_last);
  // Running max including the current sample; first sample of a window seeds it.
  assign win_max   = (win_first || x_s > max_reg) ? x_s : max_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_cnt <= '0;
      frm_cnt <= '0;
      max_reg <= '0;
    end else if (accept) begin
      max_reg <= win_max;
      win_cnt <= close ? '0 : win_cnt + 1'b1;
      frm_cnt <= frm_last ? '0 : frm_cnt + 1'b1;
    end
  end

  pool_out_reg #(.W(T)) u_out (
    .clk       (clk),
    .reset     (reset),
    .load      (close),
    .load_data (win_max),
    .y_ready   (y_ready),
    .y_data    (y_data),
    .y_valid   (y_valid),
    .ready     (x_ready)
  );

endmodule

// File: tb/tb_maxpool_1d_stream.sv
// Directed bench for maxpool_1d_stream: four instances cover K=2 full/partial frames,
// signed K=4 windows, K=1 pass-through, backpressure and asynchronous reset.
module tb_maxpool_1d_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] xd [4];
  logic        xv [4];
  logic        yr [4];
  logic        yv [4];
  logic        xr [4];
  logic [15:0] yd [4];
  logic [15:0] got [$];
  logic        pre_rdy;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  maxpool_1d_stream #(.L(32), .K(2), .T(16)) u_a (
    .clk(clk), .reset(rst), .x_data(xd[0]), .x_valid(xv[0]), .x_ready(xr[0]),
    .y_data(yd[0]), .y_valid(yv[0]), .y_ready(yr[0]));
  maxpool_1d_stream #(.L(5), .K(2), .T(16)) u_b (
    .clk(clk), .reset(rst), .x_data(xd[1]), .x_valid(xv[1]), .x_ready(xr[1]),
    .y_data(yd[1]), .y_valid(yv[1]), .y_ready(yr[1]));
  maxpool_1d_stream #(.L(8), .K(4), .T(16)) u_c (
    .clk(clk), .reset(rst), .x_data(xd[2]), .x_valid(xv[2]), .x_ready(xr[2]),
    .y_data(yd[2]), .y_valid(yv[2]), .y_ready(yr[2]));
  maxpool_1d_stream #(.L(4), .K(1), .T(16)) u_d (
    .clk(clk), .reset(rst), .x_data(xd[3]), .x_valid(xv[3]), .x_ready(xr[3]),
    .y_data(yd[3]), .y_valid(yv[3]), .y_ready(yr[3]));

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic chk_got(input string tag, input logic [15:0] e [$]);
    chk({tag, "_count"}, 16'(got.size()), 16'(e.size()));
    for (int k = 0; k < e.size(); k++)
      if (k < got.size()) chk(tag, got[k], e[k]);
  endtask

  // Called just after a falling edge: drive, sample handshake before the rising edge,
  // return on the next falling edge with the post-edge outputs settled.
  task automatic step(input int i, input logic v, input logic [15:0] d, input logic r);
    xv[i] = v; xd[i] = d; yr[i] = r;
    #1;
    pre_rdy = xr[i];
    if (yv[i] && yr[i]) got.push_back(yd[i]);
    @(negedge clk);
  endtask

  function automatic logic [15:0] smax(input logic [15:0] a, input logic [15:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  initial begin
    logic [15:0] vals [32];
    logic [15:0] exp_q [$];
    int xr_low;

    for (int i = 0; i < 4; i++) begin
      xv[i] = 1'b0; xd[i] = '0; yr[i] = 1'b1;
    end
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("rst_yv", 16'(yv[0]), 16'd0);
    chk("rst_yd", yd[0], 16'd0);
    chk("rst_xr", 16'(xr[0]), 16'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Full frame, L=32 K=2, no backpressure
    for (int j = 0; j < 32; j++) vals[j] = 16'((j * 37) % 50 - 20);
    vals[0] = 16'd0; vals[1] = 16'd5; vals[2] = 16'd3;
    vals[3] = 16'd3; vals[4] = 16'd7; vals[5] = 16'd1;
    got.delete();
    xr_low = 0;
    for (int j = 0; j < 32; j++) begin
      step(0, 1'b1, vals[j], 1'b1);
      if (!pre_rdy) xr_low++;
      if (j == 1) begin
        chk("lat_yv", 16'(yv[0]), 16'd1);
        chk("lat_yd", yd[0], 16'd5);
      end
    end
    step(0, 1'b0, 16'd0, 1'b1);
    chk("f32_xr_low", 16'(xr_low), 16'd0);
    exp_q.delete();
    for (int k = 0; k < 16; k++) exp_q.push_back(smax(vals[2*k], vals[2*k+1]));
    chk_got("f32_out", exp_q);

    // Backpressure on the K=2 instance
    got.delete();
    step(0, 1'b1, 16'd11, 1'b0);
    chk("bp_first_yv", 16'(yv[0]), 16'd0);
    step(0, 1'b1, 16'd22, 1'b0);
    chk("bp_close_yv", 16'(yv[0]), 16'd1);
    chk("bp_close_yd", yd[0], 16'd22);
    step(0, 1'b1, 16'd5, 1'b0);
    chk("bp_xr_low", 16'(pre_rdy), 16'd0);
    chk("bp_hold_yv", 16'(yv[0]), 16'd1);
    chk("bp_hold_yd", yd[0], 16'd22);
    step(0, 1'b1, 16'd5, 1'b0);
    chk("bp_hold2_yd", yd[0], 16'd22);
    step(0, 1'b1, 16'd5, 1'b1);
    chk("bp_xr_up", 16'(pre_rdy), 16'd1);
    chk("bp_emit_yv", 16'(yv[0]), 16'd0);
    step(0, 1'b1, 16'd6, 1'b1);
    chk("bp_next_yv", 16'(yv[0]), 16'd1);
    chk("bp_next_yd", yd[0], 16'd6);
    step(0, 1'b0, 16'd0, 1'b1);
    chk("bp_drain_yv", 16'(yv[0]), 16'd0);
    exp_q = {16'd22, 16'd6};
    chk_got("bp_sb", exp_q);

    // Partial last window, L=5 K=2, two frames
    got.delete();
    step(1, 1'b1, 16'd4, 1'b1); step(1, 1'b1, 16'd9, 1'b1);
    step(1, 1'b1, 16'd2, 1'b1); step(1, 1'b1, 16'd8, 1'b1);
    step(1, 1'b1, 16'd6, 1'b1); step(1, 1'b1, 16'd1, 1'b1);
    step(1, 1'b1, 16'd3, 1'b1); step(1, 1'b1, 16'd2, 1'b1);
    step(1, 1'b1, 16'd0, 1'b1); step(1, 1'b1, 16'd9, 1'b1);
    step(1, 1'b0, 16'd0, 1'b1);
    exp_q = {16'd9, 16'd8, 16'd6, 16'd3, 16'd2, 16'd9};
    chk_got("l5_out", exp_q);

    // Signed windows and ties, L=8 K=4
    got.delete();
    step(2, 1'b1, 16'd0, 1'b1);    step(2, 1'b1, 16'(-5), 1'b1);
    step(2, 1'b1, 16'd0, 1'b1);    step(2, 1'b1, 16'(-5), 1'b1);
    step(2, 1'b1, 16'(-3), 1'b1);  step(2, 1'b1, 16'(-1), 1'b1);
    step(2, 1'b1, 16'(-7), 1'b1);  step(2, 1'b1, 16'(-2), 1'b1);
    chk("sgn_yd", yd[2], 16'(-1));
    step(2, 1'b0, 16'd0, 1'b1);
    exp_q = {16'd0, 16'(-1)};
    chk_got("sgn_out", exp_q);

    // K=1: every accept closes a window while the previous result is emitted
    for (int j = 1; j <= 5; j++) begin
      step(3, 1'b1, 16'(j * 10), 1'b1);
      chk("k1_xr", 16'(pre_rdy), 16'd1);
      chk("k1_yv", 16'(yv[3]), 16'd1);
      chk("k1_yd", yd[3], 16'(j * 10));
    end
    step(3, 1'b0, 16'd0, 1'b1);
    chk("k1_drain_yv", 16'(yv[3]), 16'd0);

    // Asynchronous reset between edges, mid-window on the K=4 instance
    step(2, 1'b1, 16'd10, 1'b1);
    step(2, 1'b1, 16'd20, 1'b1);
    xv[2] = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("arst_yv", 16'(yv[2]), 16'd0);
    chk("arst_xr", 16'(xr[2]), 16'd1);
    chk("arst_yd", yd[2], 16'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    got.delete();
    step(2, 1'b1, 16'd1, 1'b1); step(2, 1'b1, 16'd2, 1'b1);
    step(2, 1'b1, 16'd3, 1'b1); step(2, 1'b1, 16'd4, 1'b1);
    step(2, 1'b0, 16'd0, 1'b1);
    exp_q = {16'd4};
    chk_got("arst_out", exp_q);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/maxpool_1d_stream.md
# maxpool_1d_stream

Streaming 1-D max-pool stage placed directly downstream of the parallel convolution engine. It consumes the convolution's ReLU'd output stream (L = N−M+1 samples per frame, one sample per handshake) and emits the maximum of each non-overlapping window of K samples. The output is a single-entry registered stream, so it can feed the next layer's x loader at full throughput.

## Interface
- `L`, default 32: samples per input frame (the 96/65 conv gives 32).
- `K`, default 2: pool window size; stride equals K. Requires 1 ≤ K ≤ L.
- `T`, default 16: sample width, signed two's complement.
- `clk`, input, 1: the single clock; all state updates on its rising edge.
- `reset`, input, 1: asynchronous, active-low. One clock; reset is asynchronous and active-low.
- `x_data`, input, T: input sample, signed.
- `x_valid`, input, 1: upstream sample valid.
- `x_ready`, output, 1: block accepts `x_data` this cycle.
- `y_data`, output, T: pooled result, signed.
- `y_valid`, output, 1: `y_data` holds an unconsumed result.
- `y_ready`, input, 1: downstream accepts `y_data` this cycle.

## Operation
- Accept occurs when `x_valid && x_ready`. Emit occurs when `y_valid && y_ready`.
- `win_cnt` (0..K−1) counts position in the window. `frm_cnt` (0..L−1) counts position in the frame.
- `max_reg`:
  - On the first sample of a window (`win_cnt==0`), it loads `x_data` unconditionally.
  - Otherwise it loads `x_data` only if `x_data > max_reg` (signed compare). Ties keep the old value; the result is identical either way.
- Window closes on an accept where `win_cnt==K−1` or `frm_cnt==L−1`. The last window of a frame may be partial (L mod K samples) and is still emitted.
- On window close:
  - `y_data` ← max(`max_reg`, `x_data`), or `x_data` alone if `win_cnt==0`.
  - `y_valid` ← 1.
  - `win_cnt` ← 0.
- `frm_cnt` wraps to 0 after L−1. `win_cnt` is also forced to 0 at the frame end, so windows never straddle frames.
- Outputs per frame = ceil(L/K).
- Output FSM:
  - EMPTY (`y_valid`=0) → FULL on window close.
  - FULL → EMPTY on emit without a simultaneous close.
  - FULL stays FULL on emit together with a simultaneous close; the new result overwrites.
- No arithmetic widening: the output equals one of the inputs, so no saturation is needed.

## Timing
- Reset values: `y_valid`=0, `y_data`=0, `x_ready`=1, `win_cnt`=0, `frm_cnt`=0, `max_reg`=0, FSM=EMPTY.
- `x_ready` = `!y_valid || y_ready` (combinational from `y_ready`). There is no combinational path from `x_valid` to `x_ready`.
- Latency: the accept that closes a window drives `y_valid`=1 on the next cycle.
- Throughput is one sample per cycle when `y_ready` is held high.
- Backpressure: while FULL and `y_ready`=0, `x_ready`=0 even for mid-window samples. `y_data` and `y_valid` remain stable until emit.
- Reset mid-window or mid-frame: the partial window is discarded and counters restart at frame sample 0.
- K==1 degenerates to a registered pass-through, with one output per input.

## Structure
- Package `cnn_pkg` holds shared widths only: the `LOGSIZE` helper via `$clog2` and the `T`-wide signed sample typedef `sample_t`, shared with the conv blocks.
- One sub-module, `pool_out_reg`: a single-entry valid/ready holding register with load, emit and overwrite-on-simultaneous behaviour.
- The top level holds the counters, `max_reg` and the compare.

## Test plan
- L=32, K=2, `y_ready`=1, inputs 0,5,3,3,7,1,… → outputs 5,3,7,… with 16 outputs per frame. `x_ready` is high every cycle.
- L=5, K=2, inputs 4,9,2,8,6 → outputs 9,8,6 (partial last window). The next frame restarts the window alignment.
- Signed values, K=4, inputs −3,−1,−7,−2 → output −1. Inputs 0,−5,0,−5 → output 0.
- Backpressure, K=2, `y_ready`=0 after the first result:
  - `x_ready` drops the cycle after close; `y_data` is held.
  - Raising `y_ready` for one cycle emits the result while accepting the next sample.
  - No sample is lost or duplicated (check against the scoreboard).
- Simultaneous emit and close at K=1 with `y_ready`=1 and continuous `x_valid` → `y_valid` stays 1 and each cycle shows the previous input.
- Assert `reset` low asynchronously, between clock edges, mid-window after inputs 10,20 (K=4).
  - Required immediately: `y_valid`=0, `x_ready`=1.
  - Then inputs 1,2,3,4 → output 4, not 20.
